// File: rtl/channel_accum_pkg.sv
// Shared widths and saturation limits for the channel accumulator and the
// stages that reuse its saturation logic.
package channel_accum_pkg;

   localparam int DATA_W    = 16;
   localparam int ACC_GUARD = 4;
   localparam int PHASE_W   = 3;

   localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/channel_accum_if.sv
// Partial-sum input, per-channel controls and result handshake of the
// channel accumulator.
interface channel_accum_if;
   import channel_accum_pkg::*;

   logic                      in_valid;
   logic [PHASE_W-1:0]        in_phase;
   logic signed [DATA_W-1:0]  in_data;
   logic                      in_ready;
   logic signed [DATA_W-1:0]  bias;
   logic                      relu_en;
   logic                      out_valid;
   logic                      out_ready;
   logic signed [DATA_W-1:0]  out_data;
   logic                      err;

   modport master (
      output in_valid, in_phase, in_data, bias, relu_en, out_ready,
      input  in_ready, out_valid, out_data, err
   );

   modport slave (
      input  in_valid, in_phase, in_data, bias, relu_en, out_ready,
      output in_ready, out_valid, out_data, err
   );

endinterface

// File: rtl/channel_accum_sat_relu.sv
// Optional ReLU followed by signed saturation of a wide accumulator value
// down to DATA_W bits. Purely combinational so other stages can reuse it.
module channel_accum_sat_relu
   import channel_accum_pkg::*;
#(
   parameter int ACC_W = DATA_W + ACC_GUARD
) (
   input  logic signed [ACC_W-1:0]  s,
   input  logic                     relu_en,
   output logic signed [DATA_W-1:0] y
);

   localparam logic signed [ACC_W-1:0] MAX_EXT = {{(ACC_W-DATA_W){1'b0}}, SAT_MAX};
   localparam logic signed [ACC_W-1:0] MIN_EXT = {{(ACC_W-DATA_W){1'b1}}, SAT_MIN};

   function automatic logic signed [DATA_W-1:0] sat_relu_f(
      input logic signed [ACC_W-1:0] v,
      input logic                    en
   );
      logic signed [ACC_W-1:0] t;
      t = (en && v[ACC_W-1]) ? '0 : v;
      if (t > MAX_EXT)
         return SAT_MAX;
      else if (t < MIN_EXT)
         return SAT_MIN;
      else
         return t[DATA_W-1:0];
   endfunction

   // Clamp negatives when requested, then saturate to the output width.
   always_comb y = sat_relu_f(s, relu_en);

endmodule

// File: rtl/channel_accum.sv
// Accumulates NUM_PHASE partial dot products for one output channel, adds
// the channel bias, applies optional ReLU with saturation and hands the
// result downstream over a valid/ready handshake.
module channel_accum
   import channel_accum_pkg::*;
#(
   parameter int NUM_PHASE = 4,
   parameter int GUARD     = ACC_GUARD
) (
   input logic             clk,
   input logic             rst,
   channel_accum_if.slave  chan
);

   localparam int ACC_W = DATA_W + GUARD;
   localparam logic [PHASE_W-1:0] LAST_CNT = PHASE_W'(NUM_PHASE - 1);

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      FINAL = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [PHASE_W-1:0]        cnt_q, cnt_d;
   logic                      out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0]  out_data_q, out_data_d;
   logic                      err_q, err_d;

   logic signed [ACC_W-1:0]   in_ext;
   logic signed [ACC_W-1:0]   bias_ext;
   logic signed [ACC_W-1:0]   sum;
   logic signed [DATA_W-1:0]  sat_y;

   assign in_ext   = {{GUARD{chan.in_data[DATA_W-1]}}, chan.in_data};
   assign bias_ext = {{GUARD{chan.bias[DATA_W-1]}}, chan.bias};
   assign sum      = acc_q + bias_ext;

   channel_accum_sat_relu #(
      .ACC_W (ACC_W)
   ) u_sat_relu (
      .s       (sum),
      .relu_en (chan.relu_en),
      .y       (sat_y)
   );

   // Next-state and next-register decode for the accumulate/finalise/output cycle.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      err_d       = err_q;
      case (state_q)
         ACCUM: begin
            if (chan.in_valid) begin
               acc_d = acc_q + in_ext;
               if (chan.in_phase != cnt_q)
                  err_d = 1'b1;
               if (cnt_q == LAST_CNT)
                  state_d = FINAL;
               else
                  cnt_d = cnt_q + 1'b1;
            end
         end
         FINAL: begin
            // Partials offered while the result is being formed are lost.
            if (chan.in_valid)
               err_d = 1'b1;
            out_data_d  = sat_y;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = OUT;
         end
         OUT: begin
            if (chan.in_valid)
               err_d = 1'b1;
            if (chan.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial sum or pending result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
      end
   end

   assign chan.in_ready  = (state_q == ACCUM);
   assign chan.out_valid = out_valid_q;
   assign chan.out_data  = out_data_q;
   assign chan.err       = err_q;

endmodule
